keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 123 ++++++++++++
 tb/tb_keypad_scanner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-code table for the 4x4 keypad scanner.
// Codes are indexed by {row, col}; '*' and '#' map to 0xE and 0xF.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_SCAN      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_EMIT      = 3'd2,
    ST_HELD      = 3'd3,
    ST_DEB_REL   = 3'd4
  } state_t;

  // Entry 15 first: r3c3 ... r0c0
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c}];
  endfunction

  // {valid, row index}: valid only when exactly one active-low row is asserted
  function automatic logic [2:0] single_low(input logic [3:0] rows);
    case (rows)
      4'b1110: return 3'b100;
      4'b1101: return 3'b101;
      4'b1011: return 3'b110;
      4'b0111: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_p0 <= '0;
      q    <= '0;
    end else begin
      q_p0 <= d;
      q    <= q_p0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one-cycle key strobe.
// Column drive is frozen from the accepting sample until the release is debounced.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] num,
  output logic       found,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [1:0]       col_idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       row_sync;
  logic [2:0]       hit;
  logic [3:0]       row_lat;
  logic [1:0]       row_idx_lat;
  logic             sample_hit;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  assign hit        = single_low(row_sync);
  assign sample_hit = (state == ST_SCAN) && (cnt == SCAN_LAST) && hit[2];

  // Captured pattern only matters while debouncing, so it carries no reset
  always_ff @(posedge clk) begin
    if (sample_hit) begin
      row_lat     <= row_sync;
      row_idx_lat <= hit[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_SCAN;
      col_idx  <= 2'd0;
      col      <= 4'b1110;
      cnt      <= '0;
      num      <= 4'h0;
      found    <= 1'b0;
      key_held <= 1'b0;
    end else begin
      found <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (hit[2]) begin
              state <= ST_DEB_PRESS;
            end else begin
              col_idx <= col_idx + 2'd1;
              col     <= col_drive(col_idx + 2'd1);
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_DEB_PRESS: begin
          if (row_sync != row_lat) begin
            state   <= ST_SCAN;
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= col_drive(col_idx + 2'd1);
          end else if (cnt == DEB_LAST) begin
            state    <= ST_EMIT;
            cnt      <= '0;
            found    <= 1'b1;
            num      <= key_code(row_idx_lat, col_idx);
            key_held <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_EMIT: begin
          state <= ST_HELD;
        end
        ST_HELD: begin
          if (row_sync == 4'hF) begin
            state <= ST_DEB_REL;
            cnt   <= '0;
          end
        end
        ST_DEB_REL: begin
          if (row_sync != 4'hF) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state    <= ST_SCAN;
            cnt      <= '0;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            col      <= col_drive(col_idx + 2'd1);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad switch-matrix model drives the rows from col,
// and a key-code reference derived from the keypad layout checks every accepted key.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  num;
  logic        found;
  logic        key_held;
  logic [15:0] pressed = '0;

  int compared   = 0;
  int mismatched = 0;

  int          found_cnt = 0;
  int          dbl_cnt   = 0;
  int          bad_col   = 0;
  int          held_bad  = 0;
  int          colf_bad  = 0;
  logic        prev_found = 1'b0;
  logic        mon_hold   = 1'b0;
  logic [15:0] digits     = '0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .num      (num),
    .found    (found),
    .key_held (key_held)
  );

  // Switch matrix: a pressed key shorts its row to its column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Downstream digit register and output-property monitors
  always @(negedge clk) begin
    if (rst) begin
      prev_found = 1'b0;
    end else begin
      if (found) begin
        found_cnt++;
        digits = {digits[11:0], num};
      end
      if (found && prev_found) dbl_cnt++;
      prev_found = found;
      if (!(col == 4'b1110 || col == 4'b1101 || col == 4'b1011 || col == 4'b0111)) bad_col++;
      if (mon_hold) begin
        if (key_held !== 1'b1) held_bad++;
        if (col !== 4'b0111) colf_bad++;
      end
    end
  end

  function automatic logic [3:0] code_of(input int k);
    int r;
    int c;
    r = k / 4;
    c = k % 4;
    if (c == 3) return 4'(10 + r);
    if (r < 3) return 4'(r * 3 + c + 1);
    if (c == 0) return 4'hE;
    if (c == 1) return 4'h0;
    return 4'hF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_found(input int base);
    for (int i = 0; i < 300 && found_cnt == base; i++) @(negedge clk);
    @(negedge clk);
    tick(1);
  endtask

  task automatic wait_release(input string tag);
    for (int i = 0; i < 200 && key_held !== 1'b0; i++) @(negedge clk);
    check(tag, 32'(key_held), 32'h0);
    tick(1);
  endtask

  initial begin
    int base;
    int run;
    logic [3:0] seq[$];
    logic [3:0] exp_cols[5];
    int k;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'hE);
    check("rst_num", 32'(num), 32'h0);
    check("rst_found", 32'(found), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two keys in one column are ignored and scanning continues
    base = found_cnt;
    pressed = '0;
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (seq.size() == 0 || seq[$] != col) seq.push_back(col);
    end
    while (seq.size() < 5) seq.push_back(4'h0);
    exp_cols = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    for (int i = 0; i < 5; i++) check($sformatf("multi_col%0d", i), 32'(seq[i]), 32'(exp_cols[i]));
    check("multi_found", found_cnt - base, 0);
    tick(1);
    pressed = '0;
    tick(4);

    // Clean '5' for 40 cycles
    base = found_cnt;
    pressed[5] = 1'b1;
    tick(40);
    pressed = '0;
    wait_release("rel_5");
    check("found_5", found_cnt - base, 1);
    check("num_5", 32'(num), 32'h5);

    // '#' with on/off/on bounce, then stable
    base = found_cnt;
    pressed[14] = 1'b1; tick(1);
    pressed[14] = 1'b0; tick(1);
    pressed[14] = 1'b1; tick(1);
    @(negedge clk);
    check("bounce_hash", found_cnt - base, 0);
    tick(1);
    wait_found(base);
    check("num_hash", 32'(num), 32'hF);
    tick(10);
    pressed = '0;
    wait_release("rel_hash");
    check("found_hash", found_cnt - base, 1);

    // Long hold of 'D'
    base = found_cnt;
    pressed[15] = 1'b1;
    wait_found(base);
    check("num_D", 32'(num), 32'hD);
    mon_hold = 1'b1;
    tick(170);
    mon_hold = 1'b0;
    check("held_D", held_bad, 0);
    check("colfrz_D", colf_bad, 0);
    check("found_D", found_cnt - base, 1);
    pressed = '0;
    wait_release("rel_D");

    // Reset during press debounce of '9', key kept held through reset
    base = found_cnt;
    pressed[10] = 1'b1;
    run = 0;
    for (int i = 0; i < 200 && run < SD + 2; i++) begin
      @(negedge clk);
      if (col == 4'b1011) run++;
      else run = 0;
    end
    rst = 1'b1;
    #1;
    check("rst9_found", 32'(found), 32'h0);
    check("rst9_col", 32'(col), 32'hE);
    check("rst9_num", 32'(num), 32'h0);
    check("rst9_held", 32'(key_held), 32'h0);
    tick(3);
    rst = 1'b0;
    check("rst9_nofound", found_cnt - base, 0);
    wait_found(base);
    check("found_9", found_cnt - base, 1);
    check("num_9", 32'(num), 32'h9);
    pressed = '0;
    wait_release("rel_9");

    // '1','2','3' into the digit register
    base = found_cnt;
    for (int d = 0; d < 3; d++) begin
      int b2;
      b2 = found_cnt;
      pressed[d] = 1'b1;
      wait_found(b2);
      check($sformatf("num_seq%0d", d), 32'(num), 32'(d + 1));
      tick(5);
      pressed = '0;
      wait_release($sformatf("rel_seq%0d", d));
      tick(3);
    end
    check("found_seq", found_cnt - base, 3);
    check("digits_123", 32'(digits[11:0]), 32'h123);

    // Random keys with press and release bounce
    for (int it = 0; it < 8; it++) begin
      int nb;
      k = int'($urandom_range(0, 15));
      base = found_cnt;
      nb = int'($urandom_range(0, 2));
      for (int b = 0; b < nb; b++) begin
        pressed[k] = 1'b1; tick(int'($urandom_range(1, 3)));
        pressed[k] = 1'b0; tick(int'($urandom_range(1, 3)));
      end
      pressed[k] = 1'b1;
      wait_found(base);
      check($sformatf("num_rand%0d_k%0d", it, k), 32'(num), 32'(code_of(k)));
      tick(int'($urandom_range(3, 30)));
      nb = int'($urandom_range(0, 2));
      for (int b = 0; b < nb; b++) begin
        pressed[k] = 1'b0; tick(int'($urandom_range(1, 3)));
        pressed[k] = 1'b1; tick(int'($urandom_range(2, 5)));
      end
      pressed = '0;
      wait_release($sformatf("rel_rand%0d", it));
      check($sformatf("found_rand%0d", it), found_cnt - base, 1);
      tick(int'($urandom_range(0, 6)));
    end

    check("no_double_found", dbl_cnt, 0);
    check("col_onehot", bad_col, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
